// File: rtl/bp_pkg.sv
// rtl/bp_pkg.sv - shared constants and counter helpers for the local branch predictor
package bp_pkg;

    // BTB entry layout: valid bit at the bottom, then the 32-bit target, tag on top
    localparam int BTB_VALID_BIT = 0;
    localparam int BTB_TGT_LSB   = 1;
    localparam int BTB_TGT_BITS  = 32;
    localparam int BTB_TAG_LSB   = BTB_TGT_LSB + BTB_TGT_BITS;

    // Tag covers every PC bit above the index and the two byte-offset bits
    function automatic int btb_tag_bits(input int idx_bits);
        return 30 - idx_bits;
    endfunction

    function automatic int btb_entry_bits(input int idx_bits);
        return BTB_TAG_LSB + btb_tag_bits(idx_bits);
    endfunction

    // Weakly not-taken: one below the taken threshold
    function automatic logic [31:0] ctr_reset_val(input int ctr_bits);
        return (32'd1 << (ctr_bits - 1)) - 32'd1;
    endfunction

    function automatic logic [31:0] ctr_max_val(input int ctr_bits);
        return (32'd1 << ctr_bits) - 32'd1;
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] v, input int ctr_bits);
        return (v == ctr_max_val(ctr_bits)) ? v : v + 32'd1;
    endfunction

    function automatic logic [31:0] sat_dec(input logic [31:0] v);
        return (v == 32'd0) ? v : v - 32'd1;
    endfunction

endpackage

// File: rtl/bp_lhpt_bank.sv
// rtl/bp_lhpt_bank.sv - saturating counter pattern table, two read ports, one training port
module bp_lhpt_bank
    import bp_pkg::*;
#(
    parameter int HIST_BITS = 4,
    parameter int CTR_BITS  = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [HIST_BITS-1:0] rd_idx0,
    input  logic [HIST_BITS-1:0] rd_idx1,
    output logic [CTR_BITS-1:0]  rd_ctr0,
    output logic [CTR_BITS-1:0]  rd_ctr1,
    input  logic                 wr_en,
    input  logic [HIST_BITS-1:0] wr_idx,
    input  logic                 wr_taken
);

    localparam int                  DEPTH   = 1 << HIST_BITS;
    localparam logic [CTR_BITS-1:0] CTR_RST = CTR_BITS'(ctr_reset_val(CTR_BITS));

    logic [CTR_BITS-1:0] ctr_q [DEPTH];
    logic [CTR_BITS-1:0] ctr_d [DEPTH];
    logic [31:0]         wr_next;

    // Read-modify-write of the trained counter; reads always see the registered array
    always_comb begin
        ctr_d   = ctr_q;
        wr_next = '0;
        if (wr_en) begin
            wr_next = wr_taken ? sat_inc(32'(ctr_q[wr_idx]), CTR_BITS)
                               : sat_dec(32'(ctr_q[wr_idx]));
            ctr_d[wr_idx] = wr_next[CTR_BITS-1:0];
        end
    end

    // Counter storage, cleared to weakly not-taken on reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                ctr_q[i] <= CTR_RST;
            end
        end else begin
            ctr_q <= ctr_d;
        end
    end

    assign rd_ctr0 = ctr_q[rd_idx0];
    assign rd_ctr1 = ctr_q[rd_idx1];

endmodule

// File: rtl/local_predictor_2w.sv
// rtl/local_predictor_2w.sv - two-slot local-history branch predictor with tagged BTB
module local_predictor_2w
    import bp_pkg::*;
#(
    parameter int LHR_IDX_BITS = 4,
    parameter int HIST_BITS    = 4,
    parameter int BTB_IDX_BITS = 4,
    parameter int CTR_BITS     = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [1:0]           lk_valid,
    input  logic [31:0]          lk_pc0,
    input  logic [31:0]          lk_pc1,
    output logic [1:0]           pr_valid,
    output logic [1:0]           pr_taken,
    output logic [1:0]           pr_hit,
    output logic [31:0]          pr_target0,
    output logic [31:0]          pr_target1,
    output logic [HIST_BITS-1:0] pr_hist0,
    output logic [HIST_BITS-1:0] pr_hist1,
    input  logic                 up_valid,
    input  logic [31:0]          up_pc,
    input  logic                 up_taken,
    input  logic [31:0]          up_target,
    input  logic [HIST_BITS-1:0] up_hist,
    input  logic                 up_mispredict,
    output logic [31:0]          cnt_lookups,
    output logic [31:0]          cnt_mispred
);

    localparam int LHR_DEPTH  = 1 << LHR_IDX_BITS;
    localparam int BTB_DEPTH  = 1 << BTB_IDX_BITS;
    localparam int TAG_BITS   = btb_tag_bits(BTB_IDX_BITS);
    localparam int ENTRY_BITS = btb_entry_bits(BTB_IDX_BITS);

    logic [HIST_BITS-1:0]  lhr_q [LHR_DEPTH];
    logic [HIST_BITS-1:0]  lhr_d [LHR_DEPTH];
    logic [ENTRY_BITS-1:0] btb_q [BTB_DEPTH];
    logic [ENTRY_BITS-1:0] btb_d [BTB_DEPTH];

    logic [31:0]           lk_pc     [2];
    logic [HIST_BITS-1:0]  lk_hist   [2];
    logic [ENTRY_BITS-1:0] lk_entry  [2];
    logic [CTR_BITS-1:0]   lk_ctr    [2];
    logic [1:0]            lk_hit;
    logic [1:0]            lk_taken;
    logic [31:0]           lk_target [2];

    logic [1:0]           pr_valid_q,   pr_valid_d;
    logic [1:0]           pr_taken_q,   pr_taken_d;
    logic [1:0]           pr_hit_q,     pr_hit_d;
    logic [31:0]          pr_target0_q, pr_target0_d;
    logic [31:0]          pr_target1_q, pr_target1_d;
    logic [HIST_BITS-1:0] pr_hist0_q,   pr_hist0_d;
    logic [HIST_BITS-1:0] pr_hist1_q,   pr_hist1_d;
    logic [31:0]          cnt_lookups_q, cnt_lookups_d;
    logic [31:0]          cnt_mispred_q, cnt_mispred_d;

    logic [HIST_BITS-1:0]  up_lhr_old;
    logic [ENTRY_BITS-1:0] up_entry;

    // Slot PCs index the local history and BTB tables
    always_comb begin
        lk_pc[0] = lk_pc0;
        lk_pc[1] = lk_pc1;
        for (int s = 0; s < 2; s++) begin
            lk_hist[s]  = lhr_q[lk_pc[s][LHR_IDX_BITS+1:2]];
            lk_entry[s] = btb_q[lk_pc[s][BTB_IDX_BITS+1:2]];
        end
    end

    bp_lhpt_bank #(
        .HIST_BITS (HIST_BITS),
        .CTR_BITS  (CTR_BITS)
    ) u_lhpt (
        .clk      (clk),
        .rst      (rst),
        .rd_idx0  (lk_hist[0]),
        .rd_idx1  (lk_hist[1]),
        .rd_ctr0  (lk_ctr[0]),
        .rd_ctr1  (lk_ctr[1]),
        .wr_en    (up_valid),
        .wr_idx   (up_hist),
        .wr_taken (up_taken)
    );

    // Direction and target per slot; taken needs both a strong counter and a BTB hit
    always_comb begin
        for (int s = 0; s < 2; s++) begin
            lk_hit[s]    = lk_entry[s][BTB_VALID_BIT] &&
                           (lk_entry[s][BTB_TAG_LSB +: TAG_BITS] == lk_pc[s][31:BTB_IDX_BITS+2]);
            lk_taken[s]  = lk_ctr[s][CTR_BITS-1] && lk_hit[s];
            lk_target[s] = lk_taken[s] ? lk_entry[s][BTB_TGT_LSB +: BTB_TGT_BITS]
                                       : lk_pc[s] + 32'd4;
        end
    end

    // Next prediction registers; slot 1 is squashed behind a taken slot 0
    always_comb begin
        pr_valid_d[0] = lk_valid[0];
        pr_valid_d[1] = lk_valid[1] && !(lk_valid[0] && lk_taken[0]);
        pr_taken_d[0] = pr_valid_d[0] && lk_taken[0];
        pr_taken_d[1] = pr_valid_d[1] && lk_taken[1];
        pr_hit_d[0]   = pr_valid_d[0] && lk_hit[0];
        pr_hit_d[1]   = pr_valid_d[1] && lk_hit[1];
        pr_target0_d  = lk_target[0];
        pr_target1_d  = lk_target[1];
        pr_hist0_d    = lk_hist[0];
        pr_hist1_d    = lk_hist[1];
        cnt_lookups_d = cnt_lookups_q + 32'(lk_valid[0]) + 32'(lk_valid[1]);
        cnt_mispred_d = cnt_mispred_q + 32'(up_valid && up_mispredict);
    end

    // Resolve path: shift the outcome into the branch's history, install taken targets
    always_comb begin
        lhr_d      = lhr_q;
        btb_d      = btb_q;
        up_lhr_old = lhr_q[up_pc[LHR_IDX_BITS+1:2]];
        up_entry   = '0;
        up_entry[BTB_VALID_BIT]                  = 1'b1;
        up_entry[BTB_TAG_LSB +: TAG_BITS]        = up_pc[31:BTB_IDX_BITS+2];
        up_entry[BTB_TGT_LSB +: BTB_TGT_BITS]    = up_target;
        if (up_valid) begin
            lhr_d[up_pc[LHR_IDX_BITS+1:2]] = {up_lhr_old[HIST_BITS-2:0], up_taken};
            if (up_taken) begin
                btb_d[up_pc[BTB_IDX_BITS+1:2]] = up_entry;
            end
        end
    end

    // History and BTB storage
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < LHR_DEPTH; i++) begin
                lhr_q[i] <= '0;
            end
            for (int i = 0; i < BTB_DEPTH; i++) begin
                btb_q[i] <= '0;
            end
        end else begin
            lhr_q <= lhr_d;
            btb_q <= btb_d;
        end
    end

    // Prediction outputs and performance counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pr_valid_q    <= '0;
            pr_taken_q    <= '0;
            pr_hit_q      <= '0;
            pr_target0_q  <= '0;
            pr_target1_q  <= '0;
            pr_hist0_q    <= '0;
            pr_hist1_q    <= '0;
            cnt_lookups_q <= '0;
            cnt_mispred_q <= '0;
        end else begin
            pr_valid_q    <= pr_valid_d;
            pr_taken_q    <= pr_taken_d;
            pr_hit_q      <= pr_hit_d;
            pr_target0_q  <= pr_target0_d;
            pr_target1_q  <= pr_target1_d;
            pr_hist0_q    <= pr_hist0_d;
            pr_hist1_q    <= pr_hist1_d;
            cnt_lookups_q <= cnt_lookups_d;
            cnt_mispred_q <= cnt_mispred_d;
        end
    end

    assign pr_valid    = pr_valid_q;
    assign pr_taken    = pr_taken_q;
    assign pr_hit      = pr_hit_q;
    assign pr_target0  = pr_target0_q;
    assign pr_target1  = pr_target1_q;
    assign pr_hist0    = pr_hist0_q;
    assign pr_hist1    = pr_hist1_q;
    assign cnt_lookups = cnt_lookups_q;
    assign cnt_mispred = cnt_mispred_q;

endmodule

// File: tb/tb_local_predictor_2w.sv
// tb/tb_local_predictor_2w.sv - randomized self-checking bench for local_predictor_2w
module tb_local_predictor_2w;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  lk_valid;
    logic [31:0] lk_pc0, lk_pc1;
    logic [1:0]  pr_valid, pr_taken, pr_hit;
    logic [31:0] pr_target0, pr_target1;
    logic [3:0]  pr_hist0, pr_hist1;
    logic        up_valid, up_taken, up_mispredict;
    logic [31:0] up_pc, up_target;
    logic [3:0]  up_hist;
    logic [31:0] cnt_lookups, cnt_mispred;

    always #5 clk = ~clk;

    local_predictor_2w #(
        .LHR_IDX_BITS (4),
        .HIST_BITS    (4),
        .BTB_IDX_BITS (4),
        .CTR_BITS     (2)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .lk_valid      (lk_valid),
        .lk_pc0        (lk_pc0),
        .lk_pc1        (lk_pc1),
        .pr_valid      (pr_valid),
        .pr_taken      (pr_taken),
        .pr_hit        (pr_hit),
        .pr_target0    (pr_target0),
        .pr_target1    (pr_target1),
        .pr_hist0      (pr_hist0),
        .pr_hist1      (pr_hist1),
        .up_valid      (up_valid),
        .up_pc         (up_pc),
        .up_taken      (up_taken),
        .up_target     (up_target),
        .up_hist       (up_hist),
        .up_mispredict (up_mispredict),
        .cnt_lookups   (cnt_lookups),
        .cnt_mispred   (cnt_mispred)
    );

    int vectors;
    int miscompares;

    // Reference model: plain tables indexed by PC word address modulo 16
    int          m_lhr  [16];
    int          m_lhpt [16];
    bit          m_bv   [16];
    logic [31:0] m_btag [16];
    logic [31:0] m_btgt [16];
    logic [31:0] m_lookups, m_mispred;

    logic [1:0]  e_valid, e_taken, e_hit;
    logic [31:0] e_tgt  [2];
    logic [3:0]  e_hist [2];

    task automatic model_reset();
        for (int i = 0; i < 16; i++) begin
            m_lhr[i] = 0; m_lhpt[i] = 1; m_bv[i] = 0; m_btag[i] = 0; m_btgt[i] = 0;
        end
        m_lookups = 0;
        m_mispred = 0;
    endtask

    task automatic model_predict(input logic [1:0] v, input logic [31:0] pc0, input logic [31:0] pc1);
        logic [31:0] pc;
        int i, h;
        bit hit, tk;
        for (int s = 0; s < 2; s++) begin
            pc  = (s == 0) ? pc0 : pc1;
            i   = int'((pc / 32'd4) % 32'd16);
            h   = m_lhr[i];
            hit = m_bv[i] && (m_btag[i] == pc / 32'd64);
            tk  = (m_lhpt[h] >= 2) && hit;
            e_hist[s]  = 4'(h);
            e_hit[s]   = hit;
            e_taken[s] = tk;
            e_tgt[s]   = tk ? m_btgt[i] : pc + 32'd4;
        end
        e_valid[0] = v[0];
        e_valid[1] = v[1] && !(v[0] && e_taken[0]);
    endtask

    task automatic model_update(input logic uv, input logic [31:0] upc, input logic ut,
                                input logic [31:0] utgt, input logic [3:0] uh, input logic um);
        int i;
        if (uv) begin
            if (ut) m_lhpt[uh] = (m_lhpt[uh] == 3) ? 3 : m_lhpt[uh] + 1;
            else    m_lhpt[uh] = (m_lhpt[uh] == 0) ? 0 : m_lhpt[uh] - 1;
            i = int'((upc / 32'd4) % 32'd16);
            m_lhr[i] = (m_lhr[i] * 2 + int'(ut)) % 16;
            if (ut) begin
                m_bv[i] = 1; m_btag[i] = upc / 32'd64; m_btgt[i] = utgt;
            end
            if (um) m_mispred = m_mispred + 1;
        end
    endtask

    // One clock of stimulus; expectations are computed from pre-edge model state
    task automatic step(input logic [1:0] v, input logic [31:0] pc0, input logic [31:0] pc1,
                        input logic uv, input logic [31:0] upc, input logic ut,
                        input logic [31:0] utgt, input logic [3:0] uh, input logic um);
        lk_valid = v; lk_pc0 = pc0; lk_pc1 = pc1;
        up_valid = uv; up_pc = upc; up_taken = ut; up_target = utgt; up_hist = uh; up_mispredict = um;
        model_predict(v, pc0, pc1);
        m_lookups = m_lookups + 32'(v[0]) + 32'(v[1]);
        @(posedge clk);
        #1;
        model_update(uv, upc, ut, utgt, uh, um);
        lk_valid = 2'b00;
        up_valid = 1'b0;
        up_mispredict = 1'b0;
    endtask

    task automatic look(input logic [1:0] v, input logic [31:0] pc0, input logic [31:0] pc1);
        step(v, pc0, pc1, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 1'b0);
    endtask

    task automatic upd(input logic [31:0] upc, input logic ut, input logic [31:0] utgt, input logic [3:0] uh);
        step(2'b00, 32'h0, 32'h0, 1'b1, upc, ut, utgt, uh, 1'b0);
    endtask

    task automatic test_reset();
        rst = 1'b1; lk_valid = 2'b00; lk_pc0 = 0; lk_pc1 = 0;
        up_valid = 0; up_pc = 0; up_taken = 0; up_target = 0; up_hist = 0; up_mispredict = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if (pr_valid !== 2'b00 || pr_taken !== 2'b00 || pr_hit !== 2'b00) begin
            miscompares++;
            $display("FAIL reset_flags: valid=%b taken=%b hit=%b want 00", pr_valid, pr_taken, pr_hit);
        end
        vectors++;
        if (cnt_lookups !== 32'd0 || cnt_mispred !== 32'd0) begin
            miscompares++;
            $display("FAIL reset_counters: lookups=%0d mispred=%0d want 0", cnt_lookups, cnt_mispred);
        end
        vectors++;
        if (pr_target0 !== 32'd0 || pr_hist0 !== 4'd0) begin
            miscompares++;
            $display("FAIL reset_fields: target0=%h hist0=%h want 0", pr_target0, pr_hist0);
        end
        rst = 1'b0;
    endtask

    task automatic test_first_lookup();
        look(2'b01, 32'h100, 32'h0);
        vectors++;
        if (pr_valid !== 2'b01 || pr_taken[0] !== 1'b0 || pr_hit[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL first_flags: valid=%b taken=%b hit=%b want 01/0/0", pr_valid, pr_taken, pr_hit);
        end
        vectors++;
        if (pr_target0 !== 32'h104 || pr_hist0 !== 4'h0) begin
            miscompares++;
            $display("FAIL first_target: target0=%h hist0=%h want 104/0", pr_target0, pr_hist0);
        end
    endtask

    task automatic test_x_pc();
        look(2'b00, 'x, 'x);
        vectors++;
        if (pr_valid !== 2'b00) begin
            miscompares++;
            $display("FAIL x_idle: valid=%b want 00", pr_valid);
        end
        look(2'b10, 'x, 32'h104);
        vectors++;
        if (pr_valid !== 2'b10) begin
            miscompares++;
            $display("FAIL x_slot0: valid=%b want 10", pr_valid);
        end
    endtask

    task automatic test_train();
        for (int k = 0; k < 4; k++) upd(32'h100, 1'b1, 32'h200, 4'hF);
        look(2'b01, 32'h100, 32'h0);
        vectors++;
        if (pr_taken[0] !== 1'b1 || pr_hit[0] !== 1'b1) begin
            miscompares++;
            $display("FAIL train_flags: taken=%b hit=%b want x1/x1", pr_taken, pr_hit);
        end
        vectors++;
        if (pr_target0 !== 32'h200 || pr_hist0 !== 4'hF) begin
            miscompares++;
            $display("FAIL train_target: target0=%h hist0=%h want 200/f", pr_target0, pr_hist0);
        end
    endtask

    task automatic test_squash();
        look(2'b11, 32'h100, 32'h104);
        vectors++;
        if (pr_valid !== 2'b01) begin
            miscompares++;
            $display("FAIL squash_valid: valid=%b want 01", pr_valid);
        end
        look(2'b11, 32'h104, 32'h100);
        vectors++;
        if (pr_valid !== 2'b11 || pr_taken !== 2'b10 || pr_target1 !== 32'h200) begin
            miscompares++;
            $display("FAIL no_squash: valid=%b taken=%b target1=%h want 11/10/200", pr_valid, pr_taken, pr_target1);
        end
    endtask

    task automatic test_saturation();
        // Give PC 0x344 history 0101 and a BTB entry so LHPT[5] drives its direction
        upd(32'h344, 1'b1, 32'h900, 4'h9);
        upd(32'h344, 1'b0, 32'h0,   4'h9);
        upd(32'h344, 1'b1, 32'h900, 4'h9);
        for (int k = 0; k < 5; k++) begin
            upd(32'h800, 1'b0, 32'h0, 4'h5);
            look(2'b01, 32'h344, 32'h0);
            vectors++;
            if (pr_taken[0] !== e_taken[0] || pr_taken[0] !== 1'b0 || pr_hist0 !== 4'h5) begin
                miscompares++;
                $display("FAIL sat_low_%0d: taken=%b hist0=%h want 0/5", k, pr_taken[0], pr_hist0);
            end
        end
        for (int k = 0; k < 5; k++) begin
            upd(32'h800, 1'b1, 32'h40, 4'h5);
            look(2'b01, 32'h344, 32'h0);
            vectors++;
            if (pr_taken[0] !== e_taken[0] || pr_taken[0] !== (k >= 1)) begin
                miscompares++;
                $display("FAIL sat_high_%0d: taken=%b want %b", k, pr_taken[0], e_taken[0]);
            end
        end
        upd(32'h800, 1'b0, 32'h0, 4'h5);
        look(2'b01, 32'h344, 32'h0);
        vectors++;
        if (pr_taken[0] !== 1'b1 || pr_target0 !== 32'h900) begin
            miscompares++;
            $display("FAIL sat_hold: taken=%b target0=%h want 1/900", pr_taken[0], pr_target0);
        end
    endtask

    task automatic test_same_cycle();
        // LHPT[5] is 2 here; the colliding lookup must still see 2, the next one sees 1
        step(2'b01, 32'h344, 32'h0, 1'b1, 32'h800, 1'b0, 32'h0, 4'h5, 1'b0);
        vectors++;
        if (pr_taken[0] !== 1'b1) begin
            miscompares++;
            $display("FAIL same_cycle_old: taken=%b want 1", pr_taken[0]);
        end
        look(2'b01, 32'h344, 32'h0);
        vectors++;
        if (pr_taken[0] !== 1'b0 || pr_target0 !== 32'h348) begin
            miscompares++;
            $display("FAIL same_cycle_new: taken=%b target0=%h want 0/348", pr_taken[0], pr_target0);
        end
    endtask

    task automatic test_counters();
        rst = 1'b1;
        #2;
        rst = 1'b0;
        model_reset();
        for (int k = 0; k < 10; k++) begin
            step(2'b11, 32'($urandom_range(0, 255)) * 4, 32'($urandom_range(0, 255)) * 4,
                 k < 3, 32'h500, 1'b0, 32'h0, 4'h3, k < 3);
        end
        vectors++;
        if (cnt_lookups !== 32'd20 || cnt_mispred !== 32'd3) begin
            miscompares++;
            $display("FAIL counters: lookups=%0d mispred=%0d want 20/3", cnt_lookups, cnt_mispred);
        end
        look(2'b01, 32'h100, 32'h0);
        #2;
        rst = 1'b1;
        #1;
        vectors++;
        if (cnt_lookups !== 32'd0 || cnt_mispred !== 32'd0 || pr_valid !== 2'b00) begin
            miscompares++;
            $display("FAIL async_reset: lookups=%0d mispred=%0d valid=%b want 0/0/00", cnt_lookups, cnt_mispred, pr_valid);
        end
        model_reset();
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        look(2'b01, 32'h100, 32'h0);
        vectors++;
        if (pr_valid !== 2'b01 || pr_taken[0] !== 1'b0 || cnt_lookups !== 32'd1) begin
            miscompares++;
            $display("FAIL post_reset: valid=%b taken=%b lookups=%0d want 01/0/1", pr_valid, pr_taken, cnt_lookups);
        end
    endtask

    task automatic test_random();
        logic [1:0]  v;
        logic [31:0] pc0, pc1, upc;
        logic [3:0]  uh;
        bit          bad;
        for (int n = 0; n < 400; n++) begin
            v   = 2'($urandom_range(0, 3));
            pc0 = (32'($urandom_range(0, 1)) << 12) | (32'($urandom_range(0, 15)) << 2);
            pc1 = ($urandom_range(0, 3) == 0) ? pc0
                  : (32'($urandom_range(0, 1)) << 12) | (32'($urandom_range(0, 15)) << 2);
            upc = (32'($urandom_range(0, 1)) << 12) | (32'($urandom_range(0, 15)) << 2);
            uh  = $urandom_range(0, 1) ? 4'(m_lhr[int'((upc / 32'd4) % 32'd16)]) : 4'($urandom_range(0, 15));
            step(v, pc0, pc1, 1'($urandom_range(0, 1)), upc, 1'($urandom_range(0, 1)),
                 32'($urandom) & 32'hFFFF_FFFC, uh, 1'($urandom_range(0, 1)));
            bad = (pr_valid !== e_valid) || (cnt_lookups !== m_lookups) || (cnt_mispred !== m_mispred);
            if (e_valid[0])
                bad = bad || (pr_taken[0] !== e_taken[0]) || (pr_hit[0] !== e_hit[0])
                          || (pr_target0 !== e_tgt[0]) || (pr_hist0 !== e_hist[0]);
            if (e_valid[1])
                bad = bad || (pr_taken[1] !== e_taken[1]) || (pr_hit[1] !== e_hit[1])
                          || (pr_target1 !== e_tgt[1]) || (pr_hist1 !== e_hist[1]);
            vectors++;
            if (bad) begin
                miscompares++;
                $display("FAIL random_%0d: got v=%b t=%b h=%b t0=%h t1=%h h0=%h h1=%h cl=%0d cm=%0d want v=%b t=%b h=%b t0=%h t1=%h h0=%h h1=%h cl=%0d cm=%0d",
                         n, pr_valid, pr_taken, pr_hit, pr_target0, pr_target1, pr_hist0, pr_hist1,
                         cnt_lookups, cnt_mispred, e_valid, e_taken, e_hit, e_tgt[0], e_tgt[1],
                         e_hist[0], e_hist[1], m_lookups, m_mispred);
            end
        end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        test_reset();
        test_first_lookup();
        test_x_pc();
        test_train();
        test_squash();
        test_saturation();
        test_same_cycle();
        test_counters();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/local_predictor_2w.md
# local_predictor_2w

Parametrised two-level local branch predictor for the 2-way fetch stage, with two lookup slots and one resolve/update port. Each slot's PC indexes a local history table (LHR). The history indexes a saturating-counter pattern table (LHPT), and a tagged BTB supplies the target. The predictor replaces the single-slot, fixed-size, mixed-edge predictor: everything is on one clock edge, and it adds slot-1 squash on a slot-0 taken prediction and performance counters. Results feed next-PC selection; the update port is driven from EX.

## Interface
Parameters:
- LHR_IDX_BITS, 4, PC bits [LHR_IDX_BITS+1:2] select the LHR entry.
- HIST_BITS, 4, history length; LHPT depth = 2^HIST_BITS.
- BTB_IDX_BITS, 4, BTB depth = 2^BTB_IDX_BITS, index PC[BTB_IDX_BITS+1:2].
- CTR_BITS, 2, saturating counter width (≥2).

Ports:
- clk  in  1  clock, all state on rising edge.
- Reset  in  1  asynchronous, active-high.
- lk_valid  in  2  per-slot lookup request (bit0 = slot 0, older).
- lk_pc0, lk_pc1  in  32 each  slot PCs.
- pr_valid  out  2  prediction valid, one cycle after lookup.
- pr_taken  out  2  predicted taken.
- pr_hit  out  2  BTB tag hit.
- pr_target0, pr_target1  out  32 each  predicted next PC.
- pr_hist0, pr_hist1  out  HIST_BITS each  LHPT index used (carried to EX).
- up_valid  in  1  resolved branch.
- up_pc  in  32  branch PC.
- up_taken  in  1  actual outcome.
- up_target  in  32  actual taken target.
- up_hist  in  HIST_BITS  LHPT index from prediction time.
- up_mispredict  in  1  EX detected misprediction.
- cnt_lookups, cnt_mispred  out  32 each  performance counters.

## Operation
- Lookup, per slot s:
  - h = LHR[idx(pc_s)]; c = LHPT[h].
  - hit = BTB valid && tag == pc_s[31:BTB_IDX_BITS+2].
  - taken = c MSB && hit. A predicted-taken branch without a BTB hit is forced to not-taken.
  - target = BTB target if taken, else pc_s+4 (mod 2^32).
- Slot squash: if slot 0 is valid and predicted taken, pr_valid[1] = 0 and slot-1 outputs are don't-care.
- Update when up_valid:
  - LHPT[up_hist]: saturating increment if taken, decrement otherwise; it holds at 0 and at 2^CTR_BITS-1.
  - LHR[idx(up_pc)] = {hist[HIST_BITS-2:0], up_taken}.
  - BTB entry: when taken, write {valid=1, tag, up_target}. When not taken, leave the entry unchanged.
- Counters:
  - cnt_lookups += popcount(lk_valid) each cycle.
  - cnt_mispred += 1 when up_valid && up_mispredict.
  - Both wrap at 2^32.
- Reset values (asynchronous):
  - LHPT entries = 2^(CTR_BITS-1)-1 (weakly not-taken); LHR = 0; BTB valid = 0.
  - All pr_* = 0; counters = 0.

## Timing
- Lookup latency 1 cycle: lk_* sampled at edge N, pr_* valid after edge N until edge N+1.
- Update writes at the edge where up_valid is sampled and is visible to lookups from the next edge.
- Same-edge lookup and update to the same entry: the lookup sees pre-update state. There is no bypass.
- Both slots indexing the same entry read identical state. There are no read conflicts.
- Reset asserted mid-operation clears all state immediately. The first lookup accepted is the one sampled on the first edge after deassertion.
- Undefined X on lk_pc with lk_valid = 0 must not propagate to pr_valid.

## Structure
- Package bp_pkg holds:
  - counter reset-value constant as a function of CTR_BITS;
  - sat_inc / sat_dec functions;
  - BTB entry field offsets (valid, tag, target).
- One sub-module, bp_lhpt_bank: counter array with two read ports, one write port and async reset, instantiated once.
- BTB, LHR, squash logic and counters live in the top module.

## Test plan
- Reset, then lookup 0x100 in slot 0 -> pr_valid=01, pr_taken=0, pr_hit=0, pr_target0=0x104, pr_hist0=0.
- Resolve 0x100 taken to 0x200 four times, then look up 0x100 -> pr_taken[0]=1, pr_hit[0]=1, pr_target0=0x200, pr_hist0=4'b1111.
- Predict slot 0 taken and send slot 1 = 0x104 in the same cycle -> pr_valid=01.
- Drive a not-taken update to a counter at 0 five times -> counter stays 0. Drive taken updates -> it saturates at 3 with no wrap.
- Same-cycle update and lookup of one entry -> the lookup returns the old counter value; the next cycle returns the new one.
- Three up_mispredict pulses plus 10 dual-slot lookups -> cnt_mispred=3, cnt_lookups=20. Assert Reset mid-stream -> all zero asynchronously.
